// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE / BUSY / RESP)
//   MEM_AW      : default memory address width
//   MEM_DW      : default memory data width
package mem_arb_pkg;

    localparam int MEM_AW = 14;
    localparam int MEM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req      : request vector, one bit per channel
//   ptr      : channel with highest priority this round
//   grant    : one-hot grant (all zero when nothing requests)
//   grant_id : binary index of the granted channel (0 when no grant)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_id
);

    localparam int unsigned NU = N;

    logic          found;
    logic [PW-1:0] idx;

    // Walk the channels starting at ptr, wrapping modulo N; first hit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = PW'((32'(ptr) + i) % NU);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter placing N_CH requesters onto a single
// cs/read_req/write_req memory bus, one transaction outstanding.
//   clk, reset_n             : clock, synchronous active-low reset
//   req_valid/we/addr/wdata  : per-channel request (held until req_ready)
//   req_ready                : one-hot acceptance, IDLE only
//   rsp_valid/rdata/err      : one-cycle one-hot response, err = timeout
//   cs/read_req/write_req    : memory strobes, high for the whole BUSY state
//   addrout/datatomem        : latched address / write data
//   datafrommem, mem_resp    : memory read data and completion
//   stray_resp               : sticky flag, mem_resp seen outside BUSY
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int AW      = MEM_AW,
    parameter int DW      = MEM_DW,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   req_valid,
    input  logic [N_CH-1:0]   req_we,
    input  logic [N_CH*AW-1:0] req_addr,
    input  logic [N_CH*DW-1:0] req_wdata,
    output logic [N_CH-1:0]   req_ready,
    output logic [N_CH-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              cs,
    output logic              read_req,
    output logic              write_req,
    output logic [AW-1:0]     addrout,
    output logic [DW-1:0]     datatomem,
    input  logic [DW-1:0]     datafrommem,
    input  logic              mem_resp,
    output logic              stray_resp
);

    localparam int PW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW_RAW   = $clog2(TIMEOUT + 1);
    localparam int CW       = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] LAST_CH  = PW'(N_CH - 1);

    arb_state_e    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] ch_id;
    logic          lat_we;
    logic [CW-1:0] cnt;

    logic [N_CH-1:0] grant;
    logic [PW-1:0]   grant_id;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            timed_out;
    logic            busy_done;

    rr_arbiter #(
        .N  (N_CH),
        .PW (PW)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign sel_addr  = req_addr[grant_id*AW +: AW];
    assign sel_wdata = req_wdata[grant_id*DW +: DW];

    // mem_resp takes precedence over a timeout landing on the same cycle.
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign busy_done = mem_resp || timed_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            ch_id      <= '0;
            lat_we     <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cs         <= 1'b0;
            read_req   <= 1'b0;
            write_req  <= 1'b0;
            addrout    <= '0;
            datatomem  <= '0;
            stray_resp <= 1'b0;
        end else begin
            if (mem_resp && (state != BUSY)) begin
                stray_resp <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (|grant) begin
                        ch_id     <= grant_id;
                        lat_we    <= req_we[grant_id];
                        addrout   <= sel_addr;
                        datatomem <= sel_wdata;
                        cs        <= 1'b1;
                        read_req  <= !req_we[grant_id];
                        write_req <= req_we[grant_id];
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end

                BUSY: begin
                    if (busy_done) begin
                        rsp_rdata <= (mem_resp && !lat_we) ? datafrommem : '0;
                        rsp_err   <= !mem_resp;
                        rsp_valid <= N_CH'(1) << ch_id;
                        cs        <= 1'b0;
                        read_req  <= 1'b0;
                        write_req <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    rsp_valid <= '0;
                    rr_ptr    <= (ch_id == LAST_CH) ? '0 : ch_id + 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (N_CH=2, TIMEOUT=8) with a
// cycle-level reference model compared on every falling edge.
module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int TO = 8;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, datatomem, datafrommem;
    logic [AW-1:0]   addrout;
    logic            rsp_err, cs, read_req, write_req, mem_resp, stray_resp;

    mem_port_arbiter #(
        .N_CH    (N),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .cs          (cs),
        .read_req    (read_req),
        .write_req   (write_req),
        .addrout     (addrout),
        .datatomem   (datatomem),
        .datafrommem (datafrommem),
        .mem_resp    (mem_resp),
        .stray_resp  (stray_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: transaction in flight, response cycle, pointer.
    bit            m_busy  = 0;
    bit            m_resp  = 0;
    int            m_age   = 0;
    int            m_ch    = 0;
    int            m_ptr   = 0;
    bit            m_we    = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err   = 0;
    bit            m_stray = 0;

    // Observation counters and grant log.
    int cyc        = 0;
    int cs_cycles  = 0;
    int rd_cycles  = 0;
    int rsp_count  = 0;
    int grant_log[$];
    int grant_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Falling-edge compare against the model, then advance the model
    // using the inputs that will be seen at the coming rising edge.
    task automatic sample();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
        int w;
        cyc++;

        exp_ready = '0;
        if (!m_busy && !m_resp) begin
            w = pick(req_valid, m_ptr);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        exp_rsp = m_resp ? (N'(1) << m_ch) : '0;

        check("req_ready",  32'(req_ready),  32'(exp_ready));
        check("rsp_valid",  32'(rsp_valid),  32'(exp_rsp));
        check("rsp_rdata",  32'(rsp_rdata),  32'(m_rdata));
        check("rsp_err",    32'(rsp_err),    32'(m_err));
        check("cs",         32'(cs),         32'(m_busy));
        check("read_req",   32'(read_req),   32'(m_busy && !m_we));
        check("write_req",  32'(write_req),  32'(m_busy && m_we));
        check("stray_resp", 32'(stray_resp), 32'(m_stray));
        if (m_busy) begin
            check("addrout",   32'(addrout),   32'(m_addr));
            check("datatomem", 32'(datatomem), 32'(m_wdata));
        end

        if (cs)       cs_cycles++;
        if (read_req) rd_cycles++;
        if (rsp_valid != '0) rsp_count++;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
            end
        end

        if (!reset_n) begin
            m_busy = 0; m_resp = 0; m_age = 0; m_ptr = 0;
            m_ch = 0; m_rdata = '0; m_err = 0; m_stray = 0;
        end else if (m_busy) begin
            m_age++;
            if (mem_resp) begin
                m_rdata = m_we ? '0 : datafrommem;
                m_err   = 0;
                m_busy  = 0;
                m_resp  = 1;
            end else if (TO != 0 && m_age == TO) begin
                m_rdata = '0;
                m_err   = 1;
                m_busy  = 0;
                m_resp  = 1;
            end
        end else begin
            if (mem_resp) m_stray = 1;
            if (m_resp) begin
                m_resp = 0;
                m_ptr  = (m_ch + 1) % N;
            end else begin
                w = pick(req_valid, m_ptr);
                if (w >= 0) begin
                    m_busy  = 1;
                    m_age   = 0;
                    m_ch    = w;
                    m_we    = req_we[w];
                    m_addr  = req_addr[w*AW +: AW];
                    m_wdata = req_wdata[w*DW +: DW];
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    // One transaction: request, bounded wait for acceptance, mem_resp on
    // BUSY cycle resp_at (0 = never), bounded wait for the response pulse.
    task automatic do_txn(input int ch, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int resp_at, input logic [DW-1:0] md,
                          output logic [N-1:0] v, output logic [DW-1:0] d, output logic e);
        int ng;
        bit got;
        bit seen;
        got  = 0;
        seen = 0;
        v = '0; d = '0; e = 1'b0;
        req_valid = '0;
        req_valid[ch] = 1'b1;
        req_we[ch] = we;
        req_addr[ch*AW +: AW] = addr;
        req_wdata[ch*DW +: DW] = wd;
        for (int t = 0; t < 8 && !got; t++) begin
            ng = grant_log.size();
            step();
            if (grant_log.size() > ng) got = 1;
        end
        req_valid = '0;
        check("accept", 32'(got), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid != '0) begin
                seen = 1;
                v = rsp_valid; d = rsp_rdata; e = rsp_err;
                break;
            end
            if (k == resp_at) begin
                mem_resp = 1'b1;
                datafrommem = md;
            end
            step();
            mem_resp = 1'b0;
        end
        check("rsp_arrived", 32'(seen), 32'd1);
        step();
    endtask

    logic [N-1:0]  v;
    logic [DW-1:0] d;
    logic          e;
    int s0, s1, base;

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        datafrommem = '0; mem_resp = 1'b0;
        @(posedge clk); #1;
        step(); step();
        reset_n = 1'b1;

        check("rst_cs",        32'(cs),         32'd0);
        check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        check("rst_stray",     32'(stray_resp), 32'd0);
        check("rst_rdata",     32'(rsp_rdata),  32'd0);
        step();

        // Single read, mem_resp on the second BUSY cycle.
        s0 = rd_cycles; s1 = rsp_count;
        do_txn(0, 0, 14'h0123, 16'h0000, 2, 16'hBEEF, v, d, e);
        check("rd_read_cycles", 32'(rd_cycles - s0), 32'd2);
        check("rd_rsp_count",   32'(rsp_count - s1), 32'd1);
        check("rd_rsp_valid",   32'(v), 32'h1);
        check("rd_rdata",       32'(d), 32'hBEEF);
        check("rd_err",         32'(e), 32'd0);

        // Round robin: both channels request continuously, memory answers at once.
        reset_n = 1'b0; step(); reset_n = 1'b1;
        base = grant_log.size();
        req_we = '0;
        req_addr[0*AW +: AW] = 14'h0010;
        req_addr[1*AW +: AW] = 14'h0020;
        datafrommem = 16'h5A5A;
        req_valid = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 12) req_valid = '0;
            mem_resp = cs;
        end
        mem_resp = 1'b0;
        check("rr_grants", 32'(grant_log.size() - base), 32'd4);
        if (grant_log.size() - base == 4) begin
            check("rr_order0", 32'(grant_log[base]),     32'd0);
            check("rr_order1", 32'(grant_log[base + 1]), 32'd1);
            check("rr_order2", 32'(grant_log[base + 2]), 32'd0);
            check("rr_order3", 32'(grant_log[base + 3]), 32'd1);
            check("rr_gap1", 32'(grant_cyc[base + 1] - grant_cyc[base]),     32'd3);
            check("rr_gap2", 32'(grant_cyc[base + 2] - grant_cyc[base + 1]), 32'd3);
            check("rr_gap3", 32'(grant_cyc[base + 3] - grant_cyc[base + 2]), 32'd3);
        end
        step();

        // Timeout on a write that never completes.
        s0 = cs_cycles;
        do_txn(0, 1, 14'h3FFF, 16'hC0DE, 0, 16'h0000, v, d, e);
        check("to_cs_cycles", 32'(cs_cycles - s0), 32'd8);
        check("to_rsp_valid", 32'(v), 32'h1);
        check("to_err",       32'(e), 32'd1);
        check("to_rdata",     32'(d), 32'h0);

        do_txn(1, 0, 14'h0055, 16'h0000, 1, 16'h1234, v, d, e);
        check("after_to_valid", 32'(v), 32'h2);
        check("after_to_rdata", 32'(d), 32'h1234);
        check("after_to_err",   32'(e), 32'd0);

        // mem_resp on the final BUSY cycle beats the timeout.
        s0 = cs_cycles;
        do_txn(0, 0, 14'h0100, 16'h0000, 8, 16'h00AA, v, d, e);
        check("edge_cs_cycles", 32'(cs_cycles - s0), 32'd8);
        check("edge_err",       32'(e), 32'd0);
        check("edge_rdata",     32'(d), 32'h00AA);

        // Reset in the middle of BUSY abandons the transaction.
        req_we[0] = 1'b0;
        req_addr[0*AW +: AW] = 14'h0200;
        req_valid = 2'b01;
        step();
        req_valid = '0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rstb_cs",       32'(cs),        32'd0);
        check("rstb_read_req", 32'(read_req),  32'd0);
        check("rstb_rsp",      32'(rsp_valid), 32'd0);
        s1 = rsp_count;
        step(); step(); step();
        check("rstb_no_rsp", 32'(rsp_count - s1), 32'd0);
        req_valid = 2'b11;
        #1;
        check("rstb_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;
        step();
        do_txn(1, 0, 14'h0333, 16'h0000, 1, 16'h7777, v, d, e);
        check("rstb_ch1_valid", 32'(v), 32'h2);
        check("rstb_ch1_rdata", 32'(d), 32'h7777);

        // Stray mem_resp in IDLE.
        s1 = rsp_count;
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check("stray_set", 32'(stray_resp), 32'd1);
        step(); step(); step();
        check("stray_sticky", 32'(stray_resp), 32'd1);
        check("stray_no_rsp", 32'(rsp_count - s1), 32'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("stray_cleared", 32'(stray_resp), 32'd0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the single-requester TinyALU memory port: arbitrates N requesters (ALU datapath, loader, debug, ...) onto one cs/read_req/write_req memory bus.
- Round-robin fairness, one outstanding transaction, per-transaction response with timeout error.
- Sits between processor cores and the memory model / SRAM controller.

Parameters:
- N_CH, 2, number of requester channels (1..8)
- AW, 14, address width
- DW, 16, data width
- TIMEOUT, 64, cycles to wait for mem_resp before erroring; 0 = never time out

Ports:
- clk  in  1  clock, all logic on posedge
- reset_n  in  1  reset
- req_valid  in  N_CH  per-channel request valid
- req_we  in  N_CH  1 = write, 0 = read
- req_addr  in  N_CH*AW  per-channel address, channel i at [i*AW +: AW]
- req_wdata  in  N_CH*DW  per-channel write data
- req_ready  out  N_CH  one-hot acceptance
- rsp_valid  out  N_CH  one-hot response pulse
- rsp_rdata  out  DW  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- cs  out  1  memory chip select
- read_req  out  1  memory read strobe
- write_req  out  1  memory write strobe
- addrout  out  AW  memory address
- datatomem  out  DW  memory write data
- datafrommem  in  DW  memory read data
- mem_resp  in  1  memory completion
- stray_resp  out  1  sticky: mem_resp seen while not BUSY

Behaviour:
- Reset: reset_n is synchronous, active-low.
  - All outputs 0, state IDLE, rr pointer 0, timeout counter 0, stray_resp 0.
  - Reset mid-transaction abandons it: no rsp_valid is issued, and cs/strobes drop at the next edge.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Winner = first channel with req_valid, searching from the rr pointer upward, modulo N_CH.
  - req_ready[winner] is driven combinationally in IDLE only. At most one bit is set.
  - On the edge where valid&ready: latch channel id, we, addr, wdata. Go to BUSY. Counter cleared.
- BUSY:
  - cs=1, read_req=!we, write_req=we, addrout/datatomem = latched values, all stable for the whole state.
  - mem_resp=1: capture datafrommem (reads; 0 for writes) and set err=0. Go to RESP.
  - Otherwise the counter increments. When counter == TIMEOUT-1 and TIMEOUT != 0, set err=1 and rdata=0, then go to RESP.
  - If mem_resp arrives on the timeout cycle, mem_resp wins (err=0).
- RESP:
  - cs/strobes 0. rsp_valid[id]=1 for exactly one cycle; rsp_rdata/rsp_err hold their captured values.
  - rr pointer <= id+1 modulo N_CH. Go to IDLE.
- Outside the RESP pulse, rsp_valid=0 and rsp_rdata/rsp_err hold their last values.
- Throughput: minimum 3 cycles per transaction (accept, BUSY with mem_resp, RESP). mem_resp may come in the first BUSY cycle.
- mem_resp in IDLE or RESP is ignored for data and sets stray_resp until reset.
- Requesters must hold req_valid/addr/wdata/we until req_ready. A deasserted req_valid without acceptance is legal (no grant).
- N_CH=1 degenerates to a pass-through with the same timing. The rr pointer stays 0.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit.

Decomposition:
- Package mem_arb_pkg: arb_state_e enum (IDLE/BUSY/RESP) and default width constants (MEM_AW=14, MEM_DW=16).
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], ptr[$clog2(N)]; outputs grant one-hot and grant_id.
  - Purely combinational; instantiated once.

Test Plan:
- Single read: ch0 read addr 0x0123, mem_resp after 2 BUSY cycles with datafrommem=0xBEEF -> read_req high 2 cycles, rsp_valid=01, rsp_rdata=0xBEEF, rsp_err=0.
- Round-robin: N_CH=2, both channels hold valid continuously for 4 transactions, mem_resp immediate -> grant order ch0, ch1, ch0, ch1, 3 cycles each.
- Timeout: TIMEOUT=8, write to 0x3FFF, mem_resp never -> cs high exactly 8 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0. Next request is serviced normally.
- Resp on timeout cycle: mem_resp on BUSY cycle 8 with data 0x00AA -> rsp_err=0, rdata=0x00AA.
- Reset mid-BUSY: reset_n low for 1 cycle during BUSY -> next cycle cs=0, no rsp_valid, pointer 0. A following ch1 request is accepted.
- Stray response: mem_resp pulsed in IDLE -> stray_resp=1, sticky until reset. rsp_valid stays 0.
